// File: rtl/acortex_i2s_pkg.sv
// Shared constants and types for the acortex I2S codec interface.
package acortex_i2s_pkg;

    localparam logic [7:0] I2S_CONTROL_REG_ADDR   = 8'h00;
    localparam logic [7:0] I2S_FRAME_CNT_REG_ADDR = 8'h01;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 2 * SLOT_BITS;

    typedef enum logic {IDLE, RUN} i2s_state_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK/LRCLK generator for the I2S master: divider, bit counter and tick strobes.
module i2s_clk_gen
    import acortex_i2s_pkg::*;
#(
    parameter int BCLK_HALF = 4
) (
    input  logic       acortex_clk,
    input  logic       acortex_rst_n,
    input  logic       run,
    output logic       aud_bclk,
    output logic       aud_lrclk,
    output logic [5:0] bit_cnt,
    output logic       rise_tick,
    output logic       fall_tick,
    output logic       frame_start
);

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             started;
    logic             div_tc;
    logic [5:0]       bit_cnt_nxt;

    assign div_tc    = (div_cnt == DIV_W'(BCLK_HALF - 1));
    assign rise_tick = run && div_tc && !aud_bclk;
    assign fall_tick = run && div_tc && aud_bclk;

    // The first falling edge after enabling opens a left slot, as does every wrap.
    assign frame_start = fall_tick && (!started || bit_cnt == 6'(FRAME_BITS - 1));
    assign bit_cnt_nxt = frame_start ? 6'd0 : bit_cnt + 6'd1;

    // NOTE: sequential state uses non-blocking assignments with an async active-low reset.
    always_ff @(posedge acortex_clk or negedge acortex_rst_n) begin
        if (!acortex_rst_n) begin
            div_cnt   <= '0;
            aud_bclk  <= 1'b0;
            aud_lrclk <= 1'b1;
            bit_cnt   <= '0;
            started   <= 1'b0;
        end else if (!run) begin
            div_cnt   <= '0;
            aud_bclk  <= 1'b0;
            aud_lrclk <= 1'b1;
            bit_cnt   <= '0;
            started   <= 1'b0;
        end else begin
            div_cnt <= div_tc ? '0 : div_cnt + DIV_W'(1);
            if (div_tc) aud_bclk <= !aud_bclk;
            if (fall_tick) begin
                bit_cnt   <= bit_cnt_nxt;
                aud_lrclk <= (bit_cnt_nxt >= 6'(SLOT_BITS));
                started   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_codec_if.sv
// I2S master front end: register block, ADC deserialiser and DAC serialiser.
// Optional build macro: I2S_CODEC_IF_LOOPBACK_EN (control bit1 routes aud_dacdat into the ADC path).
module i2s_codec_if
    import acortex_i2s_pkg::*;
#(
    parameter int LB_DATA_W = 32,
    parameter int LB_ADDR_W = 8,
    parameter int BIT_W     = 16,
    parameter int BCLK_HALF = 4
) (
    input  logic                 acortex_clk,
    input  logic                 acortex_rst_n,
    input  logic                 lb_wr_en,
    input  logic                 lb_rd_en,
    input  logic [LB_ADDR_W-1:0] lb_addr,
    input  logic [LB_DATA_W-1:0] lb_wr_data,
    output logic                 lb_wr_valid,
    output logic                 lb_rd_valid,
    output logic [LB_DATA_W-1:0] lb_rd_data,
    output logic                 adc_pcm_valid,
    output logic [31:0]          adc_lpcm_data,
    output logic [31:0]          adc_rpcm_data,
    output logic                 dac_pcm_nxt,
    input  logic [31:0]          dac_lpcm_data,
    input  logic [31:0]          dac_rpcm_data,
    output logic                 aud_bclk,
    output logic                 aud_lrclk,
    output logic                 aud_dacdat,
    input  logic                 aud_adcdat
);

    i2s_state_t           state;
    logic                 run;
    logic                 rise_tick, fall_tick, frame_start;
    logic [5:0]           bit_cnt;
    logic [6:0]           bit_pos;
    logic                 cap_l, cap_r, adc_bit, publish;
    logic [BIT_W-1:0]     adc_l_sr, adc_r_sr;
    logic [FRAME_BITS-1:0] dac_sr;
    logic [SLOT_BITS-1:0] dac_l_al, dac_r_al;
    logic                 frame_full, frame_start_q;
    logic [15:0]          frame_cnt;
    logic                 ctrl_wr;
    logic [LB_DATA_W-1:0] ctrl_rd_val;
    logic                 unused_wr_bits;

    assign run            = (state == RUN);
    assign ctrl_wr        = lb_wr_en && (lb_addr == LB_ADDR_W'(I2S_CONTROL_REG_ADDR));
    assign unused_wr_bits = ^lb_wr_data;

    i2s_clk_gen #(.BCLK_HALF(BCLK_HALF)) u_clk_gen (
        .acortex_clk   (acortex_clk),
        .acortex_rst_n (acortex_rst_n),
        .run           (run),
        .aud_bclk      (aud_bclk),
        .aud_lrclk     (aud_lrclk),
        .bit_cnt       (bit_cnt),
        .rise_tick     (rise_tick),
        .fall_tick     (fall_tick),
        .frame_start   (frame_start)
    );

`ifdef I2S_CODEC_IF_LOOPBACK_EN
    logic loopback;

    always_ff @(posedge acortex_clk or negedge acortex_rst_n) begin
        if (!acortex_rst_n)  loopback <= 1'b0;
        else if (ctrl_wr)    loopback <= lb_wr_data[1];
    end

    assign adc_bit = loopback ? aud_dacdat : aud_adcdat;
`else
    assign adc_bit = aud_adcdat;
`endif

    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        ctrl_rd_val    = '0;
        ctrl_rd_val[0] = run;
`ifdef I2S_CODEC_IF_LOOPBACK_EN
        ctrl_rd_val[1] = loopback;
`endif
    end

    always_ff @(posedge acortex_clk or negedge acortex_rst_n) begin
        if (!acortex_rst_n) begin
            state       <= IDLE;
            lb_wr_valid <= 1'b0;
            lb_rd_valid <= 1'b0;
            lb_rd_data  <= '0;
            frame_cnt   <= '0;
        end else begin
            lb_wr_valid <= lb_wr_en;
            lb_rd_valid <= lb_rd_en;
            if (ctrl_wr) state <= lb_wr_data[0] ? RUN : IDLE;
            if (ctrl_wr && lb_wr_data[0] && !run) frame_cnt <= '0;
            else if (publish)                     frame_cnt <= frame_cnt + 16'd1;
            if (lb_rd_en) begin
                if (lb_addr == LB_ADDR_W'(I2S_CONTROL_REG_ADDR))
                    lb_rd_data <= ctrl_rd_val;
                else if (lb_addr == LB_ADDR_W'(I2S_FRAME_CNT_REG_ADDR))
                    lb_rd_data <= LB_DATA_W'(frame_cnt);
                else
                    lb_rd_data <= LB_DATA_W'(32'hdeadbabe);
            end
        end
    end

    // ADC bits sit one BCLK behind each slot edge; at BIT_W = 32 the right LSB
    // would fall after the frame boundary and is not captured.
    assign bit_pos = {1'b0, bit_cnt};
    assign cap_l   = rise_tick && (bit_pos >= 7'd1) && (bit_pos <= 7'(BIT_W));
    assign cap_r   = rise_tick && (bit_pos >= 7'(SLOT_BITS + 1)) && (bit_pos <= 7'(SLOT_BITS + BIT_W));
    assign publish = frame_start && frame_full;

    assign dac_l_al = dac_lpcm_data << (SLOT_BITS - BIT_W);
    assign dac_r_al = dac_rpcm_data << (SLOT_BITS - BIT_W);

    always_ff @(posedge acortex_clk or negedge acortex_rst_n) begin
        if (!acortex_rst_n) begin
            adc_l_sr      <= '0;
            adc_r_sr      <= '0;
            dac_sr        <= '0;
            aud_dacdat    <= 1'b0;
            frame_full    <= 1'b0;
            frame_start_q <= 1'b0;
            adc_pcm_valid <= 1'b0;
            dac_pcm_nxt   <= 1'b0;
            adc_lpcm_data <= '0;
            adc_rpcm_data <= '0;
        end else if (!run) begin
            adc_l_sr      <= '0;
            adc_r_sr      <= '0;
            dac_sr        <= '0;
            aud_dacdat    <= 1'b0;
            frame_full    <= 1'b0;
            frame_start_q <= 1'b0;
            adc_pcm_valid <= 1'b0;
            dac_pcm_nxt   <= 1'b0;
        end else begin
            frame_start_q <= frame_start;
            dac_pcm_nxt   <= frame_start_q;
            adc_pcm_valid <= publish;
            if (cap_l) adc_l_sr <= {adc_l_sr[BIT_W-2:0], adc_bit};
            if (cap_r) adc_r_sr <= {adc_r_sr[BIT_W-2:0], adc_bit};
            if (fall_tick) begin
                aud_dacdat <= dac_sr[FRAME_BITS-1];
                dac_sr     <= frame_start ? {dac_l_al, dac_r_al} : dac_sr << 1;
            end
            if (frame_start) frame_full <= 1'b1;
            if (publish) begin
                adc_lpcm_data <= 32'(signed'(adc_l_sr));
                adc_rpcm_data <= 32'(signed'(adc_r_sr));
            end
        end
    end

endmodule

// File: doc/i2s_codec_if.md
Name: i2s_codec_if

Overview:
- Serial audio front end of the acortex domain; master of the codec's I2S interface.
- Generates BCLK/LRCLK from acortex_clk.
- Deserialises codec ADC data into parallel L/R PCM words, announced with a one-cycle adc_pcm_valid pulse.
- Serialises DAC words, requesting each new L/R pair with a one-cycle dac_pcm_nxt pulse; it is the producer/consumer at the other end of the PCM buffer's ADC/DAC interface.

Parameters:
- LB_DATA_W, 32, local-bus data width.
- LB_ADDR_W, 8, local-bus address width.
- BIT_W, 16, codec sample width (legal 16..32).
- BCLK_HALF, 4, acortex_clk cycles per BCLK half-period (min 2).

Ports:
- acortex_clk  in  1  system clock; all logic in this domain.
- acortex_rst_n  in  1  reset, asynchronous, active-low.
- lb_wr_en  in  1  local-bus write strobe.
- lb_rd_en  in  1  local-bus read strobe.
- lb_addr  in  LB_ADDR_W  register address.
- lb_wr_data  in  LB_DATA_W  write data.
- lb_wr_valid  out  1  write acknowledge, 1 cycle after lb_wr_en.
- lb_rd_valid  out  1  read acknowledge, 1 cycle after lb_rd_en.
- lb_rd_data  out  LB_DATA_W  read data, valid with lb_rd_valid.
- adc_pcm_valid  out  1  one-cycle pulse: new ADC L/R pair available.
- adc_lpcm_data  out  32  left ADC sample, sign-extended from BIT_W.
- adc_rpcm_data  out  32  right ADC sample, sign-extended.
- dac_pcm_nxt  out  1  one-cycle pulse: DAC pair latched, supply next.
- dac_lpcm_data  in  32  left DAC sample; low BIT_W bits used.
- dac_rpcm_data  in  32  right DAC sample.
- aud_bclk  out  1  codec bit clock.
- aud_lrclk  out  1  shared ADC/DAC LR clock; 0 = left slot.
- aud_dacdat  out  1  serial DAC data.
- aud_adcdat  in  1  serial ADC data, already synchronised externally.

Behaviour:
- Reset values:
  - All outputs 0, except aud_lrclk = 1.
  - Internal enable = 0; shift registers and counters = 0.
- Registers:
  - I2S_CONTROL_REG: bit0 = enable.
  - I2S_FRAME_CNT_REG: read-only 16-bit frame counter, wraps, cleared when enable goes 0->1.
  - A read of any other address returns 'hdeadbabe.
  - lb_wr_valid and lb_rd_valid each follow their strobe by 1 cycle.
- Clocking:
  - Divider counter 0..BCLK_HALF-1; aud_bclk toggles on terminal count.
  - rise_tick / fall_tick are the cycles on which aud_bclk is driven 1 / 0.
- Frame structure:
  - 64 BCLKs per frame: left slot = bits 0..31 (aud_lrclk 0), right slot = bits 32..63 (aud_lrclk 1).
  - aud_lrclk changes on fall_tick.
  - I2S one-bit delay: the MSB is driven on the fall_tick one BCLK after the LRCLK edge; BIT_W bits are sent MSB first, then 0 for the rest of the slot.
- ADC path:
  - aud_adcdat is sampled on rise_tick for the BIT_W bits that mirror the DAC bit positions.
  - At the LRCLK 1->0 fall_tick (start of the next left slot), adc_lpcm_data and adc_rpcm_data update together and adc_pcm_valid pulses for exactly 1 cycle.
  - Both data outputs are held stable until the next pulse.
- DAC path:
  - On the same LRCLK 1->0 fall_tick, dac_lpcm_data and dac_rpcm_data are latched into the shift registers.
  - dac_pcm_nxt pulses 1 cycle later.
  - The supplier must present the new pair before the next frame start; one frame of slack.
- State machine IDLE -> RUN -> IDLE:
  - IDLE: BCLK held 0, LRCLK held 1, no pulses.
  - IDLE -> RUN on enable = 1: the first fall_tick starts a left slot, latches DAC data and pulses dac_pcm_nxt. adc_pcm_valid is suppressed until one full frame has been captured.
  - RUN -> IDLE on enable = 0, immediately, mid-frame allowed: partial ADC data is discarded, outputs return to their reset levels, and adc_lpcm_data/adc_rpcm_data keep their last values.
- Rates: frame period = 128*BCLK_HALF acortex cycles. One adc_pcm_valid and one dac_pcm_nxt per frame.

Optional Feature:
- Macro I2S_CODEC_IF_LOOPBACK_EN.
- When defined: control bit1 = loopback. With it set, the ADC shift register samples aud_dacdat internally instead of aud_adcdat. Bit1 reads back as written.
- When undefined: bit1 is ignored and reads 0; no mux is present.

Decomposition:
- Package acortex_i2s_pkg holds:
  - I2S_CONTROL_REG_ADDR = 8'h00 and I2S_FRAME_CNT_REG_ADDR = 8'h01;
  - the state enum {IDLE, RUN};
  - the slot constant 32.
- One sub-module is natural: i2s_clk_gen, which owns the BCLK divider, bit counter, aud_bclk/aud_lrclk, and the rise_tick/fall_tick/frame_start strobes.

Test Plan:
- Enable with BCLK_HALF = 4: aud_bclk period 8 cycles, aud_lrclk period 512 cycles, dac_pcm_nxt and adc_pcm_valid one pulse each per 512 cycles.
- dac_lpcm_data = 32'h0000A5A5, dac_rpcm_data = 32'h00001234: aud_dacdat carries 1010010110100101, then 0001001000110100, each starting 1 BCLK after the LRCLK edge; zeros elsewhere.
- Codec model drives L = 16'h8001, R = 16'h1234: at the frame-start pulse, adc_lpcm_data = 32'hFFFF8001 and adc_rpcm_data = 32'h00001234; no valid pulse in the first partial frame.
- Disable mid-right-slot: aud_bclk = 0 and aud_lrclk = 1 within 1 cycle, no further pulses. Re-enable: the frame counter reads 0 and the first adc_pcm_valid arrives after one full frame.
- LB read of addr 8'h05 returns 'hdeadbabe with lb_rd_valid 1 cycle later. Frame counter reads 3 after 3 completed frames.
- With I2S_CODEC_IF_LOOPBACK_EN defined and bit1 set: adc_lpcm_data/adc_rpcm_data equal the sign-extended DAC pair from the previous frame.
